// File: rtl/sha256_job_scheduler_if.sv
// ---------------------------------------------------------------------------
// sha256_job_scheduler_if
// Bundle of the job-request side and the engine side of sha256_job_scheduler.
//   req             requester -> scheduler   level job request, one bit per requester
//   req_input_addr  requester -> scheduler   message address, slice i = [i*ADDR_W +: ADDR_W]
//   req_hash_addr   requester -> scheduler   hash output address, same slicing
//   ack             scheduler -> requester   one-cycle completion pulse to the job owner
//   busy            scheduler -> host        high from grant until the ACK state exits
//   grant_id        scheduler -> host        index of current/last granted requester
//   job_count       scheduler -> host        completed jobs, wraps 0xFFFF -> 0
//   err             scheduler -> host        sticky watchdog error
//   eng_start       scheduler -> engine      one-cycle start pulse
//   eng_input_addr  scheduler -> engine      held stable for the whole job
//   eng_hash_addr   scheduler -> engine      held stable for the whole job
//   eng_done        engine    -> scheduler   high while the engine is idle
//
// Handshake: req[i] is a level request that the requester holds (with its
// address slices) until it sees ack[i]; ack[i] is a single-cycle pulse and is
// the only completion indication. Towards the engine, eng_start is a one-cycle
// pulse issued only while eng_done is high; the job is considered running from
// the first low sample of eng_done and finished on the next high sample.
// modport slave is the scheduler; modport master is the host/engine side.
// ---------------------------------------------------------------------------
interface sha256_job_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int IDW     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_input_addr;
  logic [NUM_REQ*ADDR_W-1:0] req_hash_addr;
  logic [NUM_REQ-1:0]        ack;
  logic                      busy;
  logic [IDW-1:0]            grant_id;
  logic [15:0]               job_count;
  logic                      err;
  logic                      eng_start;
  logic [ADDR_W-1:0]         eng_input_addr;
  logic [ADDR_W-1:0]         eng_hash_addr;
  logic                      eng_done;

  modport slave (
    input  req, req_input_addr, req_hash_addr, eng_done,
    output ack, busy, grant_id, job_count, err,
           eng_start, eng_input_addr, eng_hash_addr
  );

  modport master (
    output req, req_input_addr, req_hash_addr, eng_done,
    input  ack, busy, grant_id, job_count, err,
           eng_start, eng_input_addr, eng_hash_addr
  );
endinterface

// File: rtl/sha256_job_scheduler.sv
// ---------------------------------------------------------------------------
// sha256_job_scheduler
// Shares one simplified_sha256 engine between NUM_REQ requesters. A
// round-robin arbiter picks one pending job, latches its addresses onto the
// engine pins, pulses eng_start, follows eng_done through the job and returns
// a one-cycle ack to the owner.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset (shared with the engine)
//   sched_bus    sha256_job_scheduler_if.slave (requests, ack/status, engine pins)
//   o_dbg_state  current FSM state (IDLE=0 ARB=1 START=2 WAIT_BUSY=3
//                WAIT_DONE=4 ACK=5)
//
// Optional feature: define SHA_SCHED_WATCHDOG_EN to add a per-job watchdog of
// TIMEOUT_CYCLES engine cycles. On expiry err is set (sticky), the owner still
// gets its ack, and job_count is not incremented. Without the macro err is 0
// and the wait states wait indefinitely.
// ---------------------------------------------------------------------------
module sha256_job_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  sha256_job_scheduler_if.slave         sched_bus,
  output logic [2:0]                    o_dbg_state
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARB       = 3'd1,
    S_START     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_ACK       = 3'd5
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [NUM_REQ-1:0]  r_ack, w_ack_nxt;
  logic                r_busy, w_busy_nxt;
  logic [IDW-1:0]      r_grant, w_grant_nxt;
  logic [IDW-1:0]      r_ptr, w_ptr_nxt;
  logic [15:0]         r_jobs, w_jobs_nxt;
  logic                r_err, w_err_nxt;
  logic                r_start, w_start_nxt;
  logic [ADDR_W-1:0]   r_in_addr, w_in_addr_nxt;
  logic [ADDR_W-1:0]   r_hash_addr, w_hash_addr_nxt;

  logic                w_pick_found;
  logic [IDW-1:0]      w_pick_id;
  logic                w_timeout;
  logic                w_err_hit;

  // Round-robin pick: scan downward so the last match written is the first
  // set request at or above r_ptr (with wrap).
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (sched_bus.req[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_pick_found = 1'b1;
        w_pick_id    = IDW'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end

`ifdef SHA_SCHED_WATCHDOG_EN
  logic [31:0] r_wd_cnt, w_wd_cnt_nxt;

  // Fires on the TIMEOUT_CYCLES-th cycle spent in WAIT_BUSY/WAIT_DONE.
  assign w_timeout = ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE)) &&
                     (r_wd_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_wd_cnt_nxt = r_wd_cnt;
    if (r_state == S_START) begin
      w_wd_cnt_nxt = '0;
    end else if ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE)) begin
      w_wd_cnt_nxt = r_wd_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= w_wd_cnt_nxt;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // A real completion in the same cycle as expiry counts as a normal job.
  assign w_err_hit = w_timeout && !((r_state == S_WAIT_DONE) && sched_bus.eng_done);

  // State register plus all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ack       <= '0;
      r_busy      <= 1'b0;
      r_grant     <= '0;
      r_ptr       <= '0;
      r_jobs      <= '0;
      r_err       <= 1'b0;
      r_start     <= 1'b0;
      r_in_addr   <= '0;
      r_hash_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ack       <= w_ack_nxt;
      r_busy      <= w_busy_nxt;
      r_grant     <= w_grant_nxt;
      r_ptr       <= w_ptr_nxt;
      r_jobs      <= w_jobs_nxt;
      r_err       <= w_err_nxt;
      r_start     <= w_start_nxt;
      r_in_addr   <= w_in_addr_nxt;
      r_hash_addr <= w_hash_addr_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if ((|sched_bus.req) && sched_bus.eng_done) w_state_nxt = S_ARB;
      S_ARB:       w_state_nxt = w_pick_found ? S_START : S_IDLE;
      S_START:     w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (w_timeout)               w_state_nxt = S_ACK;
        else if (!sched_bus.eng_done) w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (sched_bus.eng_done || w_timeout) w_state_nxt = S_ACK;
      S_ACK:       w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs. Values are set one
  // state early so they are visible during the state they belong to
  // (eng_start during START, ack/job_count during ACK).
  always_comb begin
    w_ack_nxt       = '0;
    w_busy_nxt      = r_busy;
    w_grant_nxt     = r_grant;
    w_ptr_nxt       = r_ptr;
    w_jobs_nxt      = r_jobs;
    w_err_nxt       = r_err;
    w_start_nxt     = 1'b0;
    w_in_addr_nxt   = r_in_addr;
    w_hash_addr_nxt = r_hash_addr;
    case (r_state)
      S_ARB: begin
        if (w_pick_found) begin
          w_grant_nxt     = w_pick_id;
          w_busy_nxt      = 1'b1;
          w_start_nxt     = 1'b1;
          w_in_addr_nxt   = sched_bus.req_input_addr[int'(w_pick_id) * ADDR_W +: ADDR_W];
          w_hash_addr_nxt = sched_bus.req_hash_addr[int'(w_pick_id) * ADDR_W +: ADDR_W];
        end else begin
          w_busy_nxt = 1'b0;
        end
      end
      S_WAIT_BUSY, S_WAIT_DONE: begin
        if (w_state_nxt == S_ACK) begin
          w_ack_nxt[r_grant] = 1'b1;
          if (w_err_hit) w_err_nxt  = 1'b1;
          else           w_jobs_nxt = r_jobs + 16'd1;
        end
      end
      S_ACK: begin
        w_busy_nxt = 1'b0;
        w_ptr_nxt  = (r_grant == IDW'(NUM_REQ - 1)) ? '0 : r_grant + IDW'(1);
      end
      default: ;
    endcase
  end

  assign sched_bus.ack            = r_ack;
  assign sched_bus.busy           = r_busy;
  assign sched_bus.grant_id       = r_grant;
  assign sched_bus.job_count      = r_jobs;
  assign sched_bus.err            = r_err;
  assign sched_bus.eng_start      = r_start;
  assign sched_bus.eng_input_addr = r_in_addr;
  assign sched_bus.eng_hash_addr  = r_hash_addr;
  assign o_dbg_state              = r_state;
endmodule
